// File: rtl/datapath_pkg.sv
// Shared datapath types and default sizes for the register status table.
package datapath_pkg;

  localparam int unsigned RST_NREGS = 32;
  localparam int unsigned RST_TAG_W = 2;
  localparam int unsigned RST_NWB   = 2;

  typedef struct packed {
    logic                 busy;
    logic [RST_TAG_W-1:0] tag;
    logic                 spec;
  } rst_entry_t;

  typedef rst_entry_t [RST_NREGS-1:0] rst_s_t;

endpackage

// File: rtl/rst_entry.sv
// One status-table entry: busy/tag/spec state with dispatch, tag-matched writeback,
// flush and resolve handling.
module rst_entry
  import datapath_pkg::*;
#(
  parameter int unsigned TAG_W = RST_TAG_W,
  parameter int unsigned NWB   = RST_NWB
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_di_hit,
  input  logic [TAG_W-1:0]          i_di_tag,
  input  logic                      i_di_spec,
  input  logic                      i_resolve,
  input  logic                      i_flush,
  input  logic [NWB-1:0]            i_wb_hit,
  input  logic [NWB-1:0][TAG_W-1:0] i_wb_tag,
  output logic                      o_busy,
  output logic [TAG_W-1:0]          o_tag,
  output logic                      o_spec,
  output logic                      o_busy_d
);

  logic             r_busy, r_spec;
  logic [TAG_W-1:0] r_tag;
  logic             w_busy_d, w_spec_d, w_wb_match;
  logic [TAG_W-1:0] w_tag_d;

  always_comb begin
    w_wb_match = 1'b0;
    for (int k = 0; k < NWB; k++) begin
      if (i_wb_hit[k] && (i_wb_tag[k] == r_tag)) w_wb_match = 1'b1;
    end
    w_wb_match = w_wb_match & r_busy;

    w_busy_d = r_busy;
    w_tag_d  = r_tag;
    w_spec_d = r_spec;
    if (w_wb_match) begin
      w_busy_d = 1'b0;
      w_spec_d = 1'b0;
    end
    if (i_flush) begin
      if (r_spec) begin
        w_busy_d = 1'b0;
        w_spec_d = 1'b0;
      end
    end else if (i_resolve) begin
      w_spec_d = 1'b0;
    end
    // Dispatch overrides writeback; a speculative one dies with a same-cycle flush.
    if (i_di_hit && !(i_flush && i_di_spec)) begin
      w_busy_d = 1'b1;
      w_tag_d  = i_di_tag;
      w_spec_d = i_di_spec;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_tag  <= '0;
      r_spec <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      r_tag  <= w_tag_d;
      r_spec <= w_spec_d;
    end
  end

  assign o_busy   = r_busy;
  assign o_tag    = r_tag;
  assign o_spec   = r_spec;
  assign o_busy_d = w_busy_d;

endmodule

// File: rtl/rst_status_table.sv
// Register status table with multi-port writeback, flush/resolve and busy counter.
// Optional RST_WB_BYPASS_EN: same-cycle matching writeback clears lookup busy.
module rst_status_table
  import datapath_pkg::*;
#(
  parameter int unsigned NREGS = RST_NREGS,
  parameter int unsigned TAG_W = RST_TAG_W,
  parameter int unsigned NWB   = RST_NWB,
  parameter int unsigned NRD   = 2,
  localparam int unsigned SEL_W = $clog2(NREGS),
  localparam int unsigned ENT_W = TAG_W + 2,
  localparam int unsigned CNT_W = SEL_W + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_di_write,
  input  logic [SEL_W-1:0]            i_di_sel,
  input  logic [TAG_W-1:0]            i_di_tag,
  input  logic                        i_di_spec,
  input  logic                        i_resolve,
  input  logic                        i_flush,
  input  logic [NWB-1:0]              i_wb_write,
  input  logic [NWB-1:0][SEL_W-1:0]   i_wb_sel,
  input  logic [NWB-1:0][TAG_W-1:0]   i_wb_tag,
  input  logic [NRD-1:0][SEL_W-1:0]   i_rd_sel,
  output logic [NRD-1:0]              o_rd_busy,
  output logic [NRD-1:0][TAG_W-1:0]   o_rd_tag,
  output logic [NREGS-1:0][ENT_W-1:0] o_status,
  output logic [CNT_W-1:0]            o_busy_count
);

  logic [NREGS-1:0]            w_busy, w_spec;
  logic [NREGS-1:0][TAG_W-1:0] w_tag;
  logic [NREGS-1:1]            w_busy_d, w_di_hit;
  logic [NREGS-1:1][NWB-1:0]   w_wb_hit;
  logic [CNT_W-1:0]            w_count_d, r_busy_count;

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      w_di_hit[i] = i_di_write && (i_di_sel == SEL_W'(i));
      for (int k = 0; k < NWB; k++) begin
        w_wb_hit[i][k] = i_wb_write[k] && (i_wb_sel[k] == SEL_W'(i));
      end
    end
  end

  // Register 0 is hardwired idle.
  assign w_busy[0] = 1'b0;
  assign w_spec[0] = 1'b0;
  assign w_tag[0]  = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_entry
    rst_entry #(
      .TAG_W(TAG_W),
      .NWB  (NWB)
    ) u_entry (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_di_hit (w_di_hit[gi]),
      .i_di_tag (i_di_tag),
      .i_di_spec(i_di_spec),
      .i_resolve(i_resolve),
      .i_flush  (i_flush),
      .i_wb_hit (w_wb_hit[gi]),
      .i_wb_tag (i_wb_tag),
      .o_busy   (w_busy[gi]),
      .o_tag    (w_tag[gi]),
      .o_spec   (w_spec[gi]),
      .o_busy_d (w_busy_d[gi])
    );
  end

  always_comb begin
    w_count_d = '0;
    for (int i = 1; i < NREGS; i++) w_count_d = w_count_d + CNT_W'(w_busy_d[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy_count <= '0;
    else       r_busy_count <= w_count_d;
  end

  assign o_busy_count = r_busy_count;

  always_comb begin
    for (int i = 0; i < NREGS; i++) o_status[i] = {w_busy[i], w_tag[i], w_spec[i]};
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      o_rd_busy[j] = w_busy[i_rd_sel[j]];
      o_rd_tag[j]  = w_tag[i_rd_sel[j]];
`ifdef RST_WB_BYPASS_EN
      for (int k = 0; k < NWB; k++) begin
        if (i_wb_write[k] && (i_wb_sel[k] == i_rd_sel[j]) &&
            (i_wb_tag[k] == w_tag[i_rd_sel[j]])) begin
          o_rd_busy[j] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_rst_status_table.sv
// Self-checking bench for rst_status_table: directed scenarios plus randomized traffic
// against a behavioural register-status model.
module tb_rst_status_table;

  localparam int NREGS = 32;
  localparam int TAG_W = 2;
  localparam int NWB   = 2;
  localparam int NRD   = 2;
  localparam int SEL_W = 5;
  localparam int EW    = TAG_W + 2;
  localparam int CW    = SEL_W + 1;

  logic                        clk;
  logic                        rst;
  logic                        di_write;
  logic [SEL_W-1:0]            di_sel;
  logic [TAG_W-1:0]            di_tag;
  logic                        di_spec;
  logic                        resolve;
  logic                        flush;
  logic [NWB-1:0]              wb_write;
  logic [NWB-1:0][SEL_W-1:0]   wb_sel;
  logic [NWB-1:0][TAG_W-1:0]   wb_tag;
  logic [NRD-1:0][SEL_W-1:0]   rd_sel;
  logic [NRD-1:0]              rd_busy;
  logic [NRD-1:0][TAG_W-1:0]   rd_tag;
  logic [NREGS-1:0][EW-1:0]    status;
  logic [CW-1:0]               busy_count;

  int n_vec = 0;
  int n_err = 0;

  logic             m_busy [NREGS];
  logic [TAG_W-1:0] m_tag  [NREGS];
  logic             m_spec [NREGS];

  rst_status_table #(
    .NREGS(NREGS),
    .TAG_W(TAG_W),
    .NWB  (NWB),
    .NRD  (NRD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_di_write  (di_write),
    .i_di_sel    (di_sel),
    .i_di_tag    (di_tag),
    .i_di_spec   (di_spec),
    .i_resolve   (resolve),
    .i_flush     (flush),
    .i_wb_write  (wb_write),
    .i_wb_sel    (wb_sel),
    .i_wb_tag    (wb_tag),
    .i_rd_sel    (rd_sel),
    .o_rd_busy   (rd_busy),
    .o_rd_tag    (rd_tag),
    .o_status    (status),
    .o_busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one architectural step from the current inputs.
  task automatic model_step();
    logic             nb [NREGS];
    logic [TAG_W-1:0] nt [NREGS];
    logic             ns [NREGS];
    int               s;
    nb = m_busy; nt = m_tag; ns = m_spec;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin nb[r] = 0; nt[r] = 0; ns[r] = 0; end
    end else begin
      for (int k = 0; k < NWB; k++) begin
        s = int'(wb_sel[k]);
        if (wb_write[k] && s != 0 && m_busy[s] && m_tag[s] == wb_tag[k]) begin
          nb[s] = 0; ns[s] = 0;
        end
      end
      for (int r = 0; r < NREGS; r++) begin
        if (flush && m_spec[r]) begin nb[r] = 0; ns[r] = 0; end
        else if (!flush && resolve) ns[r] = 0;
      end
      s = int'(di_sel);
      if (di_write && s != 0 && !(flush && di_spec)) begin
        nb[s] = 1; nt[s] = di_tag; ns[s] = di_spec;
      end
    end
    m_busy = nb; m_tag = nt; m_spec = ns;
  endtask

  function automatic logic [NREGS-1:0][EW-1:0] model_status();
    logic [NREGS-1:0][EW-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = {m_busy[r], m_tag[r], m_spec[r]};
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  task automatic idle();
    rst = 0; di_write = 0; di_sel = '0; di_tag = '0; di_spec = 0;
    resolve = 0; flush = 0; wb_write = '0; wb_sel = '0; wb_tag = '0; rd_sel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic dispatch(input int sel, input int tag, input logic spec);
    di_write = 1; di_sel = SEL_W'(sel); di_tag = TAG_W'(tag); di_spec = spec;
  endtask

  task automatic wb(input int port, input int sel, input int tag);
    wb_write[port] = 1; wb_sel[port] = SEL_W'(sel); wb_tag[port] = TAG_W'(tag);
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); idle();
    n_vec++;
    if (status !== '0) begin n_err++; $display("FAIL reset_status got %h want 0", status); end
    n_vec++;
    if (busy_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", busy_count); end
  endtask

  task automatic test_basic();
    idle(); dispatch(5, 2, 0); tick(); idle();
    n_vec++;
    if (status[5] !== 4'b1100) begin n_err++; $display("FAIL basic_alloc got %b want 1100", status[5]); end
    n_vec++;
    if (busy_count !== 6'd1) begin n_err++; $display("FAIL basic_count1 got %0d want 1", busy_count); end
    wb(0, 5, 2); tick(); idle();
    n_vec++;
    if (status[5][3] !== 1'b0 || status[5][0] !== 1'b0) begin
      n_err++; $display("FAIL basic_release got %b want 0xx0", status[5]);
    end
    n_vec++;
    if (busy_count !== 6'd0) begin n_err++; $display("FAIL basic_count0 got %0d want 0", busy_count); end
  endtask

  task automatic test_waw();
    idle(); dispatch(7, 1, 0); tick(); idle();
    dispatch(7, 3, 0); tick(); idle();
    wb(1, 7, 1); tick(); idle();
    n_vec++;
    if (status[7] !== 4'b1110) begin n_err++; $display("FAIL waw_stale got %b want 1110", status[7]); end
    wb(1, 7, 3); tick(); idle();
    n_vec++;
    if (status[7][3] !== 1'b0 || busy_count !== 6'd0) begin
      n_err++; $display("FAIL waw_release got %b/%0d want busy 0/0", status[7], busy_count);
    end
  endtask

  task automatic test_flush_resolve();
    for (int pass = 0; pass < 2; pass++) begin
      idle(); rst = 1; tick(); idle();
      dispatch(3, 0, 1); tick(); idle();
      dispatch(4, 1, 1); tick(); idle();
      dispatch(6, 2, 0); tick(); idle();
      if (pass == 0) flush = 1; else resolve = 1;
      tick(); idle();
      if (pass == 0) begin
        n_vec++;
        if (status[3][3] !== 0 || status[4][3] !== 0 || status[6] !== 4'b1100 ||
            busy_count !== 6'd1) begin
          n_err++;
          $display("FAIL flush got r3=%b r4=%b r6=%b cnt=%0d want 0xxx 0xxx 1100 1",
                   status[3], status[4], status[6], busy_count);
        end
      end else begin
        n_vec++;
        if (status[3] !== 4'b1000 || status[4] !== 4'b1010 || status[6] !== 4'b1100 ||
            busy_count !== 6'd3) begin
          n_err++;
          $display("FAIL resolve got r3=%b r4=%b r6=%b cnt=%0d want 1000 1010 1100 3",
                   status[3], status[4], status[6], busy_count);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    idle(); rst = 1; tick(); idle();
    dispatch(9, 0, 0); tick(); idle();
    dispatch(9, 0, 0); wb(0, 9, 0); tick(); idle();
    n_vec++;
    if (status[9] !== 4'b1000) begin n_err++; $display("FAIL di_wins got %b want 1000", status[9]); end
    flush = 1; dispatch(10, 1, 1); tick(); idle();
    n_vec++;
    if (status[10][3] !== 1'b0 || busy_count !== 6'd1) begin
      n_err++; $display("FAIL flush_drop got %b/%0d want 0xxx/1", status[10], busy_count);
    end
  endtask

  task automatic test_lookup_bypass();
    logic exp_b;
`ifdef RST_WB_BYPASS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    idle(); dispatch(2, 1, 0); tick(); idle();
    rd_sel[0] = 5'd2; rd_sel[1] = 5'd0; wb(0, 2, 1);
    #2;
    n_vec++;
    if (rd_busy[0] !== exp_b || rd_tag[0] !== 2'd1) begin
      n_err++; $display("FAIL bypass got %b/%0d want %b/1", rd_busy[0], rd_tag[0], exp_b);
    end
    n_vec++;
    if (rd_busy[1] !== 1'b0 || rd_tag[1] !== 2'd0) begin
      n_err++; $display("FAIL rd_zero got %b/%0d want 0/0", rd_busy[1], rd_tag[1]);
    end
    tick(); wb_write = '0; #2;
    n_vec++;
    if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL rd_after_wb got %b want 0", rd_busy[0]); end
    idle();
  endtask

  task automatic test_random();
    int   r;
    int   s;
    logic eb;
    logic [TAG_W-1:0] et;
    idle(); rst = 1; tick(); idle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst      = ($urandom_range(99) == 0);
      di_write = $urandom_range(1);
      di_sel   = SEL_W'($urandom);
      di_tag   = TAG_W'($urandom);
      di_spec  = $urandom_range(1);
      resolve  = ($urandom_range(7) == 0);
      flush    = ($urandom_range(9) == 0);
      for (int k = 0; k < NWB; k++) begin
        r = $urandom_range(NREGS - 1);
        wb_write[k] = ($urandom_range(4) < 3);
        wb_sel[k]   = SEL_W'(r);
        wb_tag[k]   = $urandom_range(1) ? m_tag[r] : TAG_W'($urandom);
      end
      for (int j = 0; j < NRD; j++) rd_sel[j] = $urandom_range(1) ? wb_sel[j] : SEL_W'($urandom);
      #2;
      for (int j = 0; j < NRD; j++) begin
        s  = int'(rd_sel[j]);
        eb = (s != 0) && m_busy[s];
        et = (s != 0) ? m_tag[s] : '0;
`ifdef RST_WB_BYPASS_EN
        for (int k = 0; k < NWB; k++) begin
          if (wb_write[k] && int'(wb_sel[k]) == s && m_tag[s] == wb_tag[k]) eb = 0;
        end
`endif
        n_vec++;
        if (rd_busy[j] !== eb || rd_tag[j] !== et) begin
          n_err++;
          $display("FAIL rand_lookup cyc %0d port %0d got %b/%0d want %b/%0d",
                   cyc, j, rd_busy[j], rd_tag[j], eb, et);
        end
      end
      tick();
      n_vec++;
      if (status !== model_status()) begin
        n_err++; $display("FAIL rand_status cyc %0d got %h want %h", cyc, status, model_status());
      end
      n_vec++;
      if (int'(busy_count) != model_count()) begin
        n_err++; $display("FAIL rand_count cyc %0d got %0d want %0d", cyc, busy_count, model_count());
      end
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle(); rst = 1; tick(); idle();
    for (int r = 1; r < NREGS; r++) begin
      dispatch(r, $urandom_range(3), 0); tick();
    end
    idle();
    n_vec++;
    if (busy_count !== 6'd31) begin n_err++; $display("FAIL fill_count got %0d want 31", busy_count); end
    dispatch(12, 3, 0); rst = 1; tick(); idle();
    n_vec++;
    if (status !== '0 || busy_count !== '0) begin
      n_err++; $display("FAIL mid_reset got %h/%0d want 0/0", status, busy_count);
    end
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin m_busy[r] = 0; m_tag[r] = 0; m_spec[r] = 0; end
    idle();
    #1;
    test_reset();
    test_basic();
    test_waw();
    test_flush_resolve();
    test_same_cycle();
    test_lookup_bypass();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rst_status_table.md
# rst_status_table

Parametrised register status table for the scoreboard. Tracks, per architectural register, whether a result is pending, which functional-unit tag will produce it, and whether the producing instruction is speculative. It sits between dispatch (allocate on issue) and writeback (release on completion). Relative to the single-port status table, it adds multiple writeback ports, tag-matched release, multiple source-lookup ports, branch resolve/flush handling and a busy-entry counter.

## Interface
- `NREGS`, default 32: number of architectural registers; power of two, ≥ 4.
- `TAG_W`, default 2: functional-unit tag width.
- `NWB`, default 2: number of writeback ports.
- `NRD`, default 2: number of source-lookup ports.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `di_write` input, 1 bit: dispatch allocates the destination register.
- `di_sel` input, `$clog2(NREGS)` bits: destination register index.
- `di_tag` input, `TAG_W` bits: producer tag.
- `di_spec` input, 1 bit: producer issued under an unresolved branch.
- `resolve` input, 1 bit: branch resolved correct; clears all spec bits.
- `flush` input, 1 bit: branch mispredicted; drops all speculative entries.
- `wb_write` input, `NWB` bits: per-port writeback valid.
- `wb_sel` input, `NWB` x `$clog2(NREGS)` bits: writeback register index.
- `wb_tag` input, `NWB` x `TAG_W` bits: writeback producer tag.
- `rd_sel` input, `NRD` x `$clog2(NREGS)` bits: lookup index.
- `rd_busy` output, `NRD` bits: looked-up register pending.
- `rd_tag` output, `NRD` x `TAG_W` bits: looked-up producer tag.
- `status` output, `NREGS` x (1+`TAG_W`+1) bits: `{busy, tag, spec}` per entry, registered.
- `busy_count` output, `$clog2(NREGS)+1` bits: number of busy entries, registered.

## Operation
- Entry state: `busy`, `tag`, `spec`. Register 0 is hardwired to not busy; writes to index 0 are ignored.
- Dispatch (`di_write`, `di_sel`≠0): busy←1, tag←`di_tag`, spec←`di_spec`. This overwrites any pending producer (WAW rename).
- Writeback port k: clears `busy` and `spec` of `wb_sel[k]` only if the entry is busy and stored tag == `wb_tag[k]`. A stale tag leaves the entry unchanged.
- Multiple writeback ports may hit distinct registers in the same cycle. If two ports hit the same register, either match clears it (logical OR).
- Dispatch and writeback to the same register in the same cycle: dispatch wins, and the new tag is installed.
- `resolve`: spec←0 on every entry.
- `flush`: every entry with spec=1 gets busy←0, spec←0. A same-cycle dispatch with `di_spec`=1 is dropped. A same-cycle dispatch with `di_spec`=0 is applied.
- `flush` and `resolve` asserted together: `flush` wins, and `resolve` is ignored.
- `busy_count` is recomputed from next-state busy bits, so it always equals the popcount of `status` busy bits.
- Lookups: `rd_busy`/`rd_tag` are read combinationally from current state. `rd_sel`=0 returns busy 0, tag 0.

## Timing
- All updates take effect on the rising edge following the request. `status` and `busy_count` reflect them one cycle later (latency 1).
- Lookups have zero latency and read pre-edge state, subject to the bypass described under Configuration.
- Reset, including reset asserted mid-operation: all entries `{0,0,0}`, `busy_count`=0. `RST` overrides every same-cycle input.
- There is no backpressure. Every input is consumed in the cycle it is valid.

## Configuration
- `RST_WB_BYPASS_EN` defined: `rd_busy` is forced to 0 when a same-cycle writeback port matches `rd_sel` with a matching tag. Dispatch allocating the same register in that cycle does not affect lookups.
- Not defined: lookups reflect registered state only. A same-cycle writeback becomes visible next cycle.
- `status` and `busy_count` are identical in both modes.

## Structure
- Shared package `datapath_pkg`:
  - `rst_entry_t {busy, tag, spec}`.
  - `rst_s_t` generalised as an array of `rst_entry_t` sized by package constants.
  - `RST_NREGS`, `RST_TAG_W`, `RST_NWB` defaults.
- Sub-module `rst_entry`: one entry's next-state logic, covering dispatch/writeback priority, tag match, flush and resolve. It is instantiated `NREGS`-1 times via generate. Counter and lookup muxes stay in the top.

## Test plan
- Reset, then dispatch r5 tag 2 non-spec → next cycle `status[5]`={1,2,0}, `busy_count`=1. Writeback r5 tag 2 → following cycle {0,·,0}, `busy_count`=0.
- Dispatch r7 tag 1, then dispatch r7 tag 3. Writeback r7 tag 1 → r7 remains busy with tag 3. Writeback r7 tag 3 → r7 cleared.
- Spec dispatches to r3, r4, non-spec to r6, then `flush` → r3 and r4 not busy, r6 busy, `busy_count`=1. Repeat with `resolve` instead of `flush` → all three remain busy with spec=0.
- Same cycle: dispatch r9 tag 0 and writeback r9 tag 0 (entry previously busy tag 0) → r9 busy tag 0. Same cycle: `flush` plus spec dispatch r10 → r10 not busy.
- r2 busy tag 1, `rd_sel`=2 with same-cycle writeback r2 tag 1 → `rd_busy`=0 with `RST_WB_BYPASS_EN` defined, 1 without. `rd_sel`=0 → busy 0.
- Fill all 31 registers, assert `RST` mid-stream with dispatch active → next cycle all entries zero, `busy_count`=0.
